// File: rtl/rsp_prep_read_ram_mc.sv
// Multi-channel RAM read sequencer: walks per-channel address windows, issues
// credit-limited reads to a fixed-latency RAM and streams words out through a FIFO.
module rsp_prep_read_ram_mc #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 18,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_STEP  = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_WIDTH  = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_mode,
    input  logic [CNT_WIDTH-1:0]         i_data_num,
    input  logic [GAP_WIDTH-1:0]         i_gap,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_start_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_end_addr,
    output logic                         o_rd_en,
    output logic [ADDR_WIDTH-1:0]        o_rd_addr,
    input  logic [DATA_WIDTH-1:0]        i_rd_data,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CH_W-1:0]              o_ch,
    output logic                         o_ch_last,
    output logic                         o_frame_last,
    output logic                         o_busy,
    output logic                         o_err
);
    localparam int CR_W = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2, S_GAP = 2'd3;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            ch_last;
        logic            frame_last;
    } tag_t;

    logic [1:0]                         state_q, state_d;
    logic                               start_q, start_qq;
    logic                               mode_q, stop_q, stop_d;
    logic [CNT_WIDTH-1:0]               num_q, wcnt_q, wcnt_d;
    logic [GAP_WIDTH-1:0]               gap_q, gcnt_q, gcnt_d;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  saddr_q, eaddr_q;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d, addr_inc, cur_end;
    logic [CH_W-1:0]                    ch_q, ch_d, ch_nxt;
    logic                               busy_q, busy_d, err_q;
    logic [CR_W-1:0]                    credits_q, credits_d;
    logic [RD_LATENCY-1:0]              vld_pipe_q;
    tag_t                               tag_pipe_q [RD_LATENCY];
    tag_t                               tag_in, tag_out;
    logic [DATA_WIDTH-1:0]              mem_data [FIFO_DEPTH];
    tag_t                               mem_tag [FIFO_DEPTH];
    logic [PW:0]                        wptr_q, rptr_q;
    logic start_edge, accept, issue, pop, push, last_word, last_ch, wrap;

    assign start_edge = start_q & ~start_qq;
    assign accept     = start_edge && (state_q == S_IDLE) && (i_data_num != '0);
    assign issue      = (state_q == S_READ) && (credits_q != '0);
    assign pop        = o_valid && i_ready;
    assign push       = vld_pipe_q[RD_LATENCY-1];
    assign last_word  = (wcnt_q == num_q - CNT_WIDTH'(1));
    assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
    assign ch_nxt     = ch_q + CH_W'(1);
    assign cur_end    = eaddr_q[ch_q];
    assign addr_inc   = addr_q + ADDR_WIDTH'(ADDR_STEP);
    // Wrap on the end address itself, or when the next step would jump past it.
    assign wrap       = (addr_q >= cur_end) || ((cur_end - addr_q) < ADDR_WIDTH'(ADDR_STEP));
    assign tag_in     = '{ch: ch_q, ch_last: last_word, frame_last: last_word && last_ch};

    always_comb begin
        state_d   = state_q;
        stop_d    = stop_q;
        wcnt_d    = wcnt_q;
        gcnt_d    = gcnt_q;
        addr_d    = addr_q;
        ch_d      = ch_q;
        busy_d    = busy_q;
        credits_d = credits_q - CR_W'(issue) + CR_W'(pop);
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_READ;
                stop_d  = 1'b0;
                ch_d    = '0;
                wcnt_d  = '0;
                addr_d  = i_start_addr[ADDR_WIDTH-1:0];
                busy_d  = 1'b1;
            end
            S_READ: begin
                if (i_stop) stop_d = 1'b1;
                if (issue) begin
                    if (last_word) begin
                        wcnt_d = '0;
                        if (last_ch) state_d = S_DRAIN;
                        else begin
                            ch_d   = ch_nxt;
                            addr_d = saddr_q[ch_nxt];
                        end
                    end else begin
                        wcnt_d = wcnt_q + CNT_WIDTH'(1);
                        addr_d = wrap ? saddr_q[ch_q] : addr_inc;
                    end
                end
            end
            S_DRAIN: begin
                if (i_stop) stop_d = 1'b1;
                if (pop && o_frame_last) begin
                    if (mode_q && !i_stop && !stop_q) begin
                        gcnt_d = '0;
                        if (gap_q == '0) begin
                            state_d = S_READ;
                            ch_d    = '0;
                            addr_d  = saddr_q[0];
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (gcnt_q == gap_q - GAP_WIDTH'(1)) begin
                    state_d = S_READ;
                    ch_d    = '0;
                    addr_d  = saddr_q[0];
                end else begin
                    gcnt_d = gcnt_q + GAP_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            start_qq   <= 1'b0;
            mode_q     <= 1'b0;
            stop_q     <= 1'b0;
            num_q      <= '0;
            gap_q      <= '0;
            wcnt_q     <= '0;
            gcnt_q     <= '0;
            saddr_q    <= '0;
            eaddr_q    <= '0;
            addr_q     <= '0;
            ch_q       <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            credits_q  <= CR_W'(FIFO_DEPTH);
            vld_pipe_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= i_start;
            start_qq  <= start_q;
            stop_q    <= stop_d;
            wcnt_q    <= wcnt_d;
            gcnt_q    <= gcnt_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            err_q     <= start_edge && !accept;
            credits_q <= credits_d;
            if (accept) begin
                mode_q  <= i_mode;
                num_q   <= i_data_num;
                gap_q   <= i_gap;
                saddr_q <= i_start_addr;
                eaddr_q <= i_end_addr;
            end
            vld_pipe_q[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            if (push) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
        end
    end

    // Tags and FIFO storage need no reset; valid bits and pointers gate them.
    always_ff @(posedge clk) begin
        tag_pipe_q[0] <= tag_in;
        for (int i = 1; i < RD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
        if (push) begin
            mem_data[wptr_q[PW-1:0]] <= i_rd_data;
            mem_tag[wptr_q[PW-1:0]]  <= tag_pipe_q[RD_LATENCY-1];
        end
    end

    assign tag_out      = mem_tag[rptr_q[PW-1:0]];
    assign o_valid      = (wptr_q != rptr_q);
    assign o_data       = o_valid ? mem_data[rptr_q[PW-1:0]] : '0;
    assign o_ch         = o_valid ? tag_out.ch : '0;
    assign o_ch_last    = o_valid && tag_out.ch_last;
    assign o_frame_last = o_valid && tag_out.frame_last;
    assign o_rd_en      = issue;
    assign o_rd_addr    = addr_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
endmodule

// File: tb/tb_rsp_prep_read_ram_mc.sv
// Scoreboard bench for rsp_prep_read_ram_mc: expected addresses and beats are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_rsp_prep_read_ram_mc;
    typedef struct packed {
        logic [127:0] d;
        logic [1:0]   ch;
        logic         cl;
        logic         fl;
    } beat_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0, i_ready = 1'b1;
    logic [15:0]  i_data_num = '0;
    logic [7:0]   i_gap = '0;
    logic [71:0]  sa_bus = '0, ea_bus = '0;
    logic         o_rd_en, o_valid, o_ch_last, o_frame_last, o_busy, o_err;
    logic [17:0]  o_rd_addr;
    logic [127:0] i_rd_data, o_data;
    logic [1:0]   o_ch;

    logic [17:0]  sa [4];
    logic [17:0]  ea [4];
    logic [17:0]  p_addr [2];
    beat_t        exp_q [$];
    logic [17:0]  exp_a [$];
    int           n_chk = 0, n_fail = 0;
    int           cyc = 0, outst = 0, fl_cnt = 0, err_cnt = 0, gap_chks = 0;
    int           fl_cyc = 0, exp_gap = 0;
    bit           gap_en = 0, gap_pend = 0, stall_v = 0;
    beat_t        mon_e, mon_act, stall_b;
    logic [17:0]  mon_a;

    rsp_prep_read_ram_mc dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_data_num(i_data_num), .i_gap(i_gap), .i_start_addr(sa_bus), .i_end_addr(ea_bus),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_ch(o_ch), .o_ch_last(o_ch_last),
        .o_frame_last(o_frame_last), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ram_word(input logic [17:0] a);
        return {14'h3A5, a, 32'(a) * 32'd7 + 32'h1357, ~{14'h0, a}, 32'hDEAD0000 ^ {14'h0, a}};
    endfunction

    // Two-cycle RAM model.
    always @(posedge clk) begin
        p_addr[0] <= o_rd_addr;
        p_addr[1] <= p_addr[0];
    end
    assign i_rd_data = ram_word(p_addr[1]);

    function automatic logic [17:0] nxt(input logic [17:0] a, input logic [17:0] s, input logic [17:0] e);
        if (a >= e || (e - a) < 18'd16) return s;
        return a + 18'd16;
    endfunction

    task automatic gen_frame(input int num);
        logic [17:0] a;
        for (int c = 0; c < 4; c++) begin
            a = sa[c];
            for (int w = 0; w < num; w++) begin
                exp_a.push_back(a);
                exp_q.push_back('{d: ram_word(a), ch: 2'(c), cl: (w == num - 1), fl: (w == num - 1) && (c == 3)});
                a = nxt(a, sa[c], ea[c]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            outst   = 0;
            stall_v = 0;
        end else begin
            if (o_rd_en) begin
                n_chk++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_addr: unexpected read at %h, required no read", o_rd_addr);
                end else begin
                    mon_a = exp_a.pop_front();
                    if (o_rd_addr !== mon_a) begin
                        n_fail++;
                        $display("FAIL rd_addr: got %h, required %h", o_rd_addr, mon_a);
                    end
                end
                if (gap_en && gap_pend) begin
                    n_chk++;
                    gap_chks++;
                    gap_pend = 0;
                    if (cyc - fl_cyc - 1 != exp_gap) begin
                        n_fail++;
                        $display("FAIL frame_gap: got %0d idle cycles, required %0d", cyc - fl_cyc - 1, exp_gap);
                    end
                end
            end
            mon_act = '{d: o_data, ch: o_ch, cl: o_ch_last, fl: o_frame_last};
            if (stall_v) begin
                n_chk++;
                if (!o_valid || mon_act !== stall_b) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid %b data %h, required valid 1 data %h", o_valid, o_data, stall_b.d);
                end
            end
            if (o_valid && i_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected beat %h, required none", o_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_act !== mon_e) begin
                        n_fail++;
                        $display("FAIL beat: got %h ch%0d cl%b fl%b, required %h ch%0d cl%b fl%b",
                                 mon_act.d, mon_act.ch, mon_act.cl, mon_act.fl, mon_e.d, mon_e.ch, mon_e.cl, mon_e.fl);
                    end
                end
                if (o_frame_last) begin
                    fl_cnt++;
                    if (gap_en) begin
                        fl_cyc   = cyc;
                        gap_pend = 1;
                    end
                end
            end
            stall_v = o_valid && !i_ready;
            stall_b = mon_act;
            outst = outst + int'(o_rd_en) - int'(o_valid && i_ready);
            n_chk++;
            if (outst > 4) begin
                n_fail++;
                $display("FAIL occupancy: got %0d outstanding, required <= 4", outst);
            end
            err_cnt += int'(o_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic set_win(input logic [17:0] base, input logic [17:0] span);
        for (int k = 0; k < 4; k++) begin
            sa[k] = base + 18'(k * 'h1000);
            ea[k] = sa[k] + span;
            sa_bus[k*18 +: 18] = sa[k];
            ea_bus[k*18 +: 18] = ea[k];
        end
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick(2);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input bit rnd, input string nm);
        int k = 0;
        @(negedge clk);
        while (o_busy && k < max) begin
            @(posedge clk);
            #1;
            if (rnd) i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (o_busy) begin
            n_fail++;
            $display("FAIL %s: busy %b after %0d cycles, required 0", nm, o_busy, max);
        end
        i_ready = 1'b1;
        tick(3);
        check({nm, "_exp_beats_left"}, exp_q.size(), 0);
        check({nm, "_exp_addrs_left"}, exp_a.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        check(nm, {o_rd_en, o_rd_addr, o_valid, o_data, o_ch, o_ch_last, o_frame_last, o_busy, o_err} == '0, 1);
    endtask

    initial begin
        int first, last, cnt, fl0, e0, g0, k;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_state");
        tick(1);

        // Basic single frame, 3 words per channel.
        set_win(18'h0, 18'h20);
        i_data_num = 16'd3;
        i_mode = 1'b0;
        gen_frame(3);
        do_start();
        first = -1; last = -1; cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (o_rd_en) begin
                if (first < 0) first = j;
                last = j;
                cnt++;
            end
        end
        check("basic_rd_count", cnt, 12);
        check("basic_rd_span", last - first, 11);
        wait_idle(100, 0, "basic");
        check("basic_busy_after", o_busy, 0);

        // Window wrap on ch0.
        set_win(18'h0, 18'h20);
        sa[0] = 18'h100; ea[0] = 18'h120;
        sa_bus[17:0] = sa[0]; ea_bus[17:0] = ea[0];
        i_data_num = 16'd5;
        gen_frame(5);
        do_start();
        wait_idle(100, 0, "wrap");

        // Random backpressure, 64 words per channel.
        set_win(18'h40, 18'h1F0);
        i_data_num = 16'd64;
        gen_frame(64);
        do_start();
        wait_idle(3000, 1, "backpressure");

        // Continuous mode, stop during frame 3.
        set_win(18'h0, 18'h20);
        i_data_num = 16'd2;
        i_mode = 1'b1;
        i_gap = 8'd10;
        exp_gap = 10;
        gap_en = 1;
        fl0 = fl_cnt;
        g0 = gap_chks;
        for (int f = 0; f < 3; f++) gen_frame(2);
        do_start();
        k = 0;
        while (fl_cnt < fl0 + 2 && k < 300) begin @(negedge clk); k++; end
        check("cont_two_frames_seen", fl_cnt - fl0, 2);
        k = 0;
        @(negedge clk);
        while (!o_rd_en && k < 50) begin @(negedge clk); k++; end
        check("cont_frame3_started", o_rd_en, 1);
        i_stop = 1'b1;
        wait_idle(200, 0, "cont_stop");
        i_stop = 1'b0;
        gap_en = 0;
        check("cont_frames", fl_cnt - fl0, 3);
        check("cont_gap_checks", gap_chks - g0, 2);
        i_mode = 1'b0;
        i_gap = 8'd0;

        // Rejected starts: zero length, then an edge while busy.
        e0 = err_cnt;
        i_data_num = 16'd0;
        do_start();
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            cnt += int'(o_busy);
        end
        check("zero_len_err", err_cnt - e0, 1);
        check("zero_len_busy", cnt, 0);
        tick(1);
        e0 = err_cnt;
        i_data_num = 16'd4;
        gen_frame(4);
        do_start();
        tick(2);
        do_start();
        wait_idle(100, 0, "busy_start");
        check("busy_start_err", err_cnt - e0, 1);

        // Synchronous reset with reads in flight.
        set_win(18'h0, 18'h3F0);
        i_data_num = 16'd64;
        gen_frame(64);
        do_start();
        k = 0; cnt = 0;
        while (cnt < 6 && k < 50) begin @(negedge clk); cnt += int'(o_rd_en); k++; end
        check("rst_reads_issued", cnt, 6);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_a.delete();
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_mid_read_zero");
        cnt = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            cnt += int'(o_valid);
        end
        check("rst_no_valid_after", cnt, 0);
        tick(1);
        set_win(18'h0, 18'h20);
        i_data_num = 16'd3;
        gen_frame(3);
        do_start();
        wait_idle(100, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end
endmodule
